pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-/multi-cycle MIPS cores.
- Holds the PC register and computes next-PC for sequential, BEQ, J/JAL, JR and ERET flow.
- Adds stall, an interrupt/exception redirect with an EPC register, and a two-state exception-level machine.
- Sits between the controller (npc_sel, stall, irq) and instruction memory (pc out).

Parameters:
- WIDTH, 32, PC/data width; must be ≥ 30.
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, handler entry address.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC/EPC/state this cycle
- npc_sel  in  3  000 SEQ, 001 BEQ, 010 J/JAL, 011 JR, 100 ERET; others are treated as SEQ
- zero  in  1  branch condition from ALU
- imme  in  26  instr[25:0]; the branch offset is imme[15:0]
- rs  in  WIDTH  $rs value for JR
- irq  in  1  level interrupt request
- pc  out  WIDTH  current PC (registered)
- pc_4  out  WIDTH  pc+4 (combinational), used as the JAL link value
- epc  out  WIDTH  saved return address (registered)
- exl  out  1  1 while in the HANDLER state

Behaviour:
- Reset (rst=1 at posedge, overriding all else):
  - pc <= RESET_PC, epc <= 0, state <= NORMAL (exl=0).
- Target computation (combinational, modulo 2^WIDTH):
  - seq = pc+4.
  - br = pc+4 + sign_extend({imme[15:0],2'b00}) to WIDTH.
  - j = {pc[WIDTH-1:28], imme, 2'b00}.
  - jr = rs.
- tgt selection:
  - SEQ: seq.
  - BEQ: br if zero, else seq.
  - J: j.
  - JR: jr.
  - ERET: epc if exl, else seq (ERET outside the handler is a NOP).
- States: NORMAL (exl=0) and HANDLER (exl=1).
- Priority each cycle: rst > stall > exception entry > normal update.
  - stall=1: pc, epc and state hold. irq is ignored this cycle; it is level-sensitive and is taken once stall drops.
  - NORMAL, irq=1: pc <= EXC_VECTOR, epc <= tgt (the address that would have executed next), state <= HANDLER.
  - NORMAL, irq=0: pc <= tgt.
  - HANDLER: irq is masked (no nesting). pc <= tgt. If npc_sel==ERET then state <= NORMAL and pc <= epc.
- Latency:
  - The pc update is visible one cycle after the sampled inputs.
  - pc_4 has zero latency.
- Boundaries:
  - pc = all-ones-minus-3 plus 4 wraps to 0.
  - Branch offsets of -1 and -32768 words must sign-extend correctly.
  - ERET and irq in the same cycle while in HANDLER: ERET is taken, and irq is sampled again in NORMAL on the next cycle.

Optional Feature:
- Macro: PC_UNIT_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign (1 bit, registered, reset 0).
  - In NORMAL, a tgt[1:0] != 0 from JR or ERET is treated as an exception entry: pc <= EXC_VECTOR, epc <= tgt, state <= HANDLER, misalign <= 1.
  - misalign clears on ERET.
  - irq has priority over misalign when both are present (misalign stays 0).
  - In HANDLER, a misaligned JR is not checked.
- Undefined:
  - No port; the target is loaded unchanged, low bits included.

Decomposition:
- Shared package mips_pkg holds:
  - NPC_SEQ/BEQ/J/JR/ERET 3-bit encodings.
  - RESET_PC and EXC_VECTOR defaults.
  - The NORMAL/HANDLER state encoding.
- One natural sub-module: npc_target, a purely combinational tgt computation from pc, imme, rs, zero, epc, exl and npc_sel. pc_unit instantiates it plus the registers and FSM.

Test Plan:
- Reset then 3 SEQ cycles -> pc = 3000, 3004, 3008, 300C; epc=0; exl=0.
- pc=3000, BEQ, imme[15:0]=FFFF, zero=1 -> pc=3000. Same with zero=0 -> pc=3004. imme[15:0]=0002, zero=1 -> pc=300C.
- pc=3000_0010, J, imme=26'h0000100 -> pc=3000_0400. Then JR with rs=0000_3020 -> pc=3020; pc_4 = 3024 during that cycle.
- pc=3010, SEQ, irq=1 -> pc=4180, epc=3014, exl=1. irq held for 2 more cycles -> pc=4184, 4188 (masked). ERET -> pc=3014, exl=0.
- stall=1 for 3 cycles with irq=1 and npc_sel=J -> pc, epc and exl unchanged. Release stall -> exception entry on the next cycle. rst mid-handler -> pc=3000, exl=0, epc=0.
- (PC_UNIT_ALIGN_CHECK_EN) JR rs=0000_3022 in NORMAL -> pc=4180, epc=3022, misalign=1. ERET -> misalign=0, pc=3022.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: next-PC select codes, reset/vector defaults
// and the exception-level state encoding.
package mips_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'b000,
    NPC_BEQ  = 3'b001,
    NPC_J    = 3'b010,
    NPC_JR   = 3'b011,
    NPC_ERET = 3'b100
  } npc_sel_e;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } exc_state_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

endpackage

// File: rtl/pc_unit_if.sv
// Controller <-> PC unit bundle. PC_UNIT_ALIGN_CHECK_EN adds the misalign flag.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic [2:0]       npc_sel;
  logic             zero;
  logic [25:0]      imme;
  logic [WIDTH-1:0] rs;
  logic             irq;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_4;
  logic [WIDTH-1:0] epc;
  logic             exl;
`ifdef PC_UNIT_ALIGN_CHECK_EN
  logic             misalign;

  modport master (output stall, npc_sel, zero, imme, rs, irq,
                  input  pc, pc_4, epc, exl, misalign);
  modport slave  (input  stall, npc_sel, zero, imme, rs, irq,
                  output pc, pc_4, epc, exl, misalign);
`else
  modport master (output stall, npc_sel, zero, imme, rs, irq,
                  input  pc, pc_4, epc, exl);
  modport slave  (input  stall, npc_sel, zero, imme, rs, irq,
                  output pc, pc_4, epc, exl);
`endif
endinterface

// File: rtl/npc_target.sv
// Combinational next-PC target: sequential, BEQ, J/JAL, JR and ERET.
module npc_target
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] epc,
  input  logic [WIDTH-1:0] rs,
  input  logic [25:0]      imme,
  input  logic             zero,
  input  logic             exl,
  input  logic [2:0]       npc_sel,
  output logic [WIDTH-1:0] seq,
  output logic [WIDTH-1:0] tgt
);

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] jmp;

  always_comb begin
    seq    = pc + WIDTH'(4);
    br_off = {{(WIDTH-18){imme[15]}}, imme[15:0], 2'b00};
    br     = seq + br_off;
    jmp    = {pc[WIDTH-1:28], imme, 2'b00};
    tgt    = seq;
    case (npc_sel)
      NPC_BEQ:  tgt = zero ? br : seq;
      NPC_J:    tgt = jmp;
      NPC_JR:   tgt = rs;
      NPC_ERET: tgt = exl ? epc : seq;
      default:  tgt = seq;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// PC register, EPC and NORMAL/HANDLER exception-level machine.
// Optional macro PC_UNIT_ALIGN_CHECK_EN: misaligned JR/ERET target traps.
module pc_unit
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEF)
) (
  input logic      clk,
  input logic      rst,
  pc_unit_if.slave bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  exc_state_e       state_q, state_d;
  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] tgt;
  logic             exl;

  assign exl = (state_q == ST_HANDLER);

  npc_target #(.WIDTH(WIDTH)) u_npc_target (
    .pc      (pc_q),
    .epc     (epc_q),
    .rs      (bus.rs),
    .imme    (bus.imme),
    .zero    (bus.zero),
    .exl     (exl),
    .npc_sel (bus.npc_sel),
    .seq     (seq),
    .tgt     (tgt)
  );

`ifdef PC_UNIT_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic bad_align;

  assign bad_align = ((bus.npc_sel == NPC_JR) || (bus.npc_sel == NPC_ERET))
                     && (tgt[1:0] != 2'b00);
  assign bus.misalign = misalign_q;
`endif

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    state_d = state_q;
`ifdef PC_UNIT_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    if (!bus.stall) begin
      unique case (state_q)
        ST_NORMAL: begin
          if (bus.irq) begin
            pc_d    = EXC_VECTOR;
            epc_d   = tgt;
            state_d = ST_HANDLER;
`ifdef PC_UNIT_ALIGN_CHECK_EN
            misalign_d = 1'b0;
          end else if (bad_align) begin
            pc_d       = EXC_VECTOR;
            epc_d      = tgt;
            state_d    = ST_HANDLER;
            misalign_d = 1'b1;
`endif
          end else begin
            pc_d = tgt;
          end
        end
        ST_HANDLER: begin
          // tgt is already epc for ERET while exl is set
          pc_d = tgt;
          if (bus.npc_sel == NPC_ERET) begin
            state_d = ST_NORMAL;
`ifdef PC_UNIT_ALIGN_CHECK_EN
            misalign_d = 1'b0;
`endif
          end
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      state_q <= ST_NORMAL;
`ifdef PC_UNIT_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      state_q <= state_d;
`ifdef PC_UNIT_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign bus.pc   = pc_q;
  assign bus.pc_4 = seq;
  assign bus.epc  = epc_q;
  assign bus.exl  = exl;

endmodule
